// File: rtl/mul_div_arbiter.sv
// Round-robin arbiter sharing one MUL/DIV execution unit among NUM_REQ requesters.
// Define MUL_DIV_ARB_STATS_EN to add per-requester 16-bit grant counters (stat_grant_cnt_bo).
module mul_div_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int REQ_W      = 80,
  parameter int RESP_W     = 40,
  parameter int RESP_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_req_i,
  input  logic [NUM_REQ*REQ_W-1:0]   req_rdata_bi,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic [NUM_REQ-1:0]         resp_req_o,
  output logic [RESP_W-1:0]          resp_wdata_bo,
  input  logic [NUM_REQ-1:0]         resp_ack_i,
  output logic                       exu_req_o,
  output logic [REQ_W-1:0]           exu_rdata_bo,
  input  logic                       exu_ack_i,
  input  logic                       exu_resp_req_i,
  input  logic [RESP_W-1:0]          exu_resp_rdata_bi,
  output logic                       exu_resp_ack_o,
  output logic                       err_o
`ifdef MUL_DIV_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      stat_grant_cnt_bo
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [CNT_W-1:0]  credits;
  logic              accept;
  int                scan;

  logic [IDX_W-1:0]  own_mem [RESP_DEPTH];
  logic [PTR_W-1:0]  own_wr, own_rd;
  logic [CNT_W-1:0]  own_cnt;
  logic              own_pop;

  logic [IDX_W-1:0]  resp_own_mem  [RESP_DEPTH];
  logic [RESP_W-1:0] resp_data_mem [RESP_DEPTH];
  logic [PTR_W-1:0]  resp_wr, resp_rd;
  logic [CNT_W-1:0]  resp_cnt;
  logic              resp_valid;
  logic [IDX_W-1:0]  head_owner;
  logic              resp_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scan downwards so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_idx = '0;
    scan      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (req_req_i[scan[IDX_W-1:0]]) grant_idx = scan[IDX_W-1:0];
    end
  end

  assign exu_req_o      = !rst_i && (|req_req_i) && (credits < CNT_W'(RESP_DEPTH));
  assign accept         = exu_req_o && exu_ack_i;
  assign exu_rdata_bo   = req_rdata_bi[grant_idx*REQ_W +: REQ_W];
  assign exu_resp_ack_o = 1'b1;

  assign own_pop    = exu_resp_req_i && (own_cnt != '0);
  assign resp_valid = (resp_cnt != '0);
  assign head_owner = resp_own_mem[resp_rd];
  assign resp_pop   = resp_valid && resp_ack_i[head_owner];
  assign resp_wdata_bo = resp_data_mem[resp_rd];

  always_comb begin
    req_ack_o  = '0;
    resp_req_o = '0;
    if (accept)     req_ack_o[grant_idx]   = 1'b1;
    if (resp_valid) resp_req_o[head_owner] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      credits <= '0;
      err_o   <= 1'b0;
    end else begin
      if (accept) rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      credits <= credits + CNT_W'(accept) - CNT_W'(resp_pop);
      if (exu_resp_req_i && (own_cnt == '0)) err_o <= 1'b1;
    end
  end

  // Owner FIFO: which requester each in-flight EXU op belongs to, in issue order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      own_wr  <= '0;
      own_rd  <= '0;
      own_cnt <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) own_mem[i] <= '0;
    end else begin
      if (accept) begin
        own_mem[own_wr] <= grant_idx;
        own_wr          <= ptr_inc(own_wr);
      end
      if (own_pop) own_rd <= ptr_inc(own_rd);
      own_cnt <= own_cnt + CNT_W'(accept) - CNT_W'(own_pop);
    end
  end

  // Response FIFO absorbs the un-backpressurable EXU pulse until the owner takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_wr  <= '0;
      resp_rd  <= '0;
      resp_cnt <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        resp_own_mem[i]  <= '0;
        resp_data_mem[i] <= '0;
      end
    end else begin
      if (own_pop) begin
        resp_own_mem[resp_wr]  <= own_mem[own_rd];
        resp_data_mem[resp_wr] <= exu_resp_rdata_bi;
        resp_wr                <= ptr_inc(resp_wr);
      end
      if (resp_pop) resp_rd <= ptr_inc(resp_rd);
      resp_cnt <= resp_cnt + CNT_W'(own_pop) - CNT_W'(resp_pop);
    end
  end

`ifdef MUL_DIV_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (accept) begin
      grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_grant_cnt_bo[gi*16 +: 16] = grant_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_mul_div_arbiter.sv
// Randomized self-checking bench for mul_div_arbiter with an in-order 2-cycle EXU model.
module tb_mul_div_arbiter;

  localparam int N   = 4;
  localparam int RW  = 80;
  localparam int SW  = 40;
  localparam int D   = 2;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [N-1:0]      req_req_i = '0;
  logic [N*RW-1:0]   req_rdata_bi = '0;
  logic [N-1:0]      req_ack_o;
  logic [N-1:0]      resp_req_o;
  logic [SW-1:0]     resp_wdata_bo;
  logic [N-1:0]      resp_ack_i = '0;
  logic              exu_req_o;
  logic [RW-1:0]     exu_rdata_bo;
  logic              exu_ack_i = 1'b0;
  logic              exu_resp_req_i = 1'b0;
  logic [SW-1:0]     exu_resp_rdata_bi = '0;
  logic              exu_resp_ack_o;
  logic              err_o;
`ifdef MUL_DIV_ARB_STATS_EN
  logic [N*16-1:0]   stat_grant_cnt_bo;
`endif

  mul_div_arbiter #(.NUM_REQ(N), .REQ_W(RW), .RESP_W(SW), .RESP_DEPTH(D)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .req_req_i         (req_req_i),
    .req_rdata_bi      (req_rdata_bi),
    .req_ack_o         (req_ack_o),
    .resp_req_o        (resp_req_o),
    .resp_wdata_bo     (resp_wdata_bo),
    .resp_ack_i        (resp_ack_i),
    .exu_req_o         (exu_req_o),
    .exu_rdata_bo      (exu_rdata_bo),
    .exu_ack_i         (exu_ack_i),
    .exu_resp_req_i    (exu_resp_req_i),
    .exu_resp_rdata_bi (exu_resp_rdata_bi),
    .exu_resp_ack_o    (exu_resp_ack_o),
    .err_o             (err_o)
`ifdef MUL_DIV_ARB_STATS_EN
    ,
    .stat_grant_cnt_bo (stat_grant_cnt_bo)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            owner;
    logic [SW-1:0] data;
    int            due;
  } op_t;

  // Model: ops at the EXU and buffered responses, both in issue order.
  op_t          pend[$];
  op_t          rsp[$];
  int           rr_m  = 0;
  logic         err_m = 1'b0;
  int           cyc   = 0;
  int           total = 0;
  int           bad   = 0;

  logic [N-1:0]  cur_req      = '0;
  logic [N-1:0]  cur_resp_ack = '0;
  logic          cur_exu_ack  = 1'b0;
  logic          cur_spur     = 1'b0;
  logic [RW-1:0] words [N];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick_grant(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int idx = (rr_m + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [SW-1:0] op_result(input logic [RW-1:0] w);
    return SW'(w[15:0]) * SW'(w[31:16]);
  endfunction

  task automatic clearModel();
    pend.delete();
    rsp.delete();
    rr_m  = 0;
    err_m = 1'b0;
  endtask

  task automatic checkOutput();
    int            credits;
    int            g;
    logic          ex;
    logic          acc;
    logic [N-1:0]  exp_ack;
    op_t           o;
    credits = pend.size() + rsp.size();
    g       = pick_grant(req_req_i);
    ex      = (g >= 0) && (credits < D);
    acc     = ex && exu_ack_i;
    exp_ack = acc ? (N'(1) << g) : N'(0);
    chk("exu_req", 128'(exu_req_o), 128'(ex));
    if (g >= 0) chk("exu_rdata", 128'(exu_rdata_bo), 128'(words[g]));
    chk("req_ack", 128'(req_ack_o), 128'(exp_ack));
    if (rsp.size() > 0) begin
      chk("resp_req", 128'(resp_req_o), 128'(N'(1) << rsp[0].owner));
      chk("resp_data", 128'(resp_wdata_bo), 128'(rsp[0].data));
    end else begin
      chk("resp_req_idle", 128'(resp_req_o), 128'(0));
    end
    chk("err", 128'(err_o), 128'(err_m));
    chk("exu_resp_ack", 128'(exu_resp_ack_o), 128'(1));
    if (rsp.size() > 0 && resp_ack_i[rsp[0].owner]) void'(rsp.pop_front());
    if (exu_resp_req_i) begin
      if (pend.size() > 0) begin
        o      = pend.pop_front();
        o.data = exu_resp_rdata_bi;
        rsp.push_back(o);
      end else begin
        err_m = 1'b1;
      end
    end
    if (acc) begin
      pend.push_back('{g, op_result(words[g]), cyc + LAT});
      rr_m = (g + 1) % N;
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    cyc++;
    #1;
    req_req_i   = cur_req;
    for (int i = 0; i < N; i++) req_rdata_bi[i*RW +: RW] = words[i];
    exu_ack_i   = cur_exu_ack;
    resp_ack_i  = cur_resp_ack;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exu_resp_req_i    = 1'b1;
      exu_resp_rdata_bi = pend[0].data;
    end else if (cur_spur) begin
      exu_resp_req_i    = 1'b1;
      exu_resp_rdata_bi = 40'hDEAD;
    end else begin
      exu_resp_req_i    = 1'b0;
      exu_resp_rdata_bi = {8'($urandom), $urandom};
    end
    #3;
    checkOutput();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_i          = 1'b1;
    req_req_i      = '0;
    exu_ack_i      = 1'b0;
    exu_resp_req_i = 1'b0;
    resp_ack_i     = '0;
    clearModel();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic randomize_words();
    for (int i = 0; i < N; i++) words[i] = {16'($urandom), $urandom, $urandom};
  endtask

  task automatic randomTraffic(input int cycles);
    logic [31:0] r;
    for (int c = 0; c < cycles; c++) begin
      r = $urandom;
      randomize_words();
      cur_req      = r[3:0];
      cur_resp_ack = r[7:4] | {4{r[8]}};
      cur_exu_ack  = (r[11:10] != 2'b00);
      cur_spur     = 1'b0;
      applyStimulus();
    end
  endtask

  initial begin
    int got[$];
    int acc_cnt;
    randomize_words();

    // Reset state while rst_i is held.
    #12;
    req_req_i = 4'b1111;
    #1;
    chk("rst_exu_req", 128'(exu_req_o), 128'(0));
    chk("rst_req_ack", 128'(req_ack_o), 128'(0));
    chk("rst_resp_req", 128'(resp_req_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_exu_resp_ack", 128'(exu_resp_ack_o), 128'(1));
    doReset();

    // Single requester, 3*5 through the 2-cycle EXU.
    words[0]     = {48'd0, 16'd5, 16'd3};
    cur_req      = 4'b0001;
    cur_exu_ack  = 1'b1;
    cur_resp_ack = 4'b0000;
    applyStimulus();
    chk("a_ack", 128'(req_ack_o), 128'(4'b0001));
    cur_req      = 4'b0000;
    cur_resp_ack = 4'b0001;
    applyStimulus();
    applyStimulus();
    chk("a_resp_early", 128'(resp_req_o), 128'(4'b0000));
    applyStimulus();
    chk("a_resp_req", 128'(resp_req_o), 128'(4'b0001));
    chk("a_resp_data", 128'(resp_wdata_bo), 128'(40'd15));
    applyStimulus();

    // All four requesting: grant order 0,1,2,3,...
    doReset();
    randomize_words();
    cur_req      = 4'b1111;
    cur_resp_ack = 4'b1111;
    cur_exu_ack  = 1'b1;
    for (int c = 0; c < 24; c++) begin
      applyStimulus();
      for (int i = 0; i < N; i++) if (req_ack_o[i]) got.push_back(i);
    end
    chk("rr_count_ok", 128'(got.size() >= 8), 128'(1));
    for (int i = 0; i < 8 && i < got.size(); i++) chk("rr_order", 128'(got[i]), 128'(i % N));

    // Requester 1 withholds its response ack: credits stall issue.
    doReset();
    cur_req      = 4'b0010;
    cur_resp_ack = 4'b0000;
    acc_cnt      = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus();
      if (req_ack_o != '0) acc_cnt++;
    end
    chk("c_accepts", 128'(acc_cnt), 128'(2));
    chk("c_stalled", 128'(exu_req_o), 128'(0));
    cur_resp_ack = 4'b0010;
    applyStimulus();
    chk("c_still_stalled", 128'(exu_req_o), 128'(0));
    applyStimulus();
    chk("c_resume", 128'(exu_req_o), 128'(1));
    for (int c = 0; c < 10; c++) applyStimulus();

    // Spurious EXU response: sticky error, nothing delivered.
    doReset();
    cur_req      = 4'b0000;
    cur_resp_ack = 4'b1111;
    cur_spur     = 1'b1;
    applyStimulus();
    cur_spur = 1'b0;
    applyStimulus();
    chk("d_err", 128'(err_o), 128'(1));
    chk("d_no_resp", 128'(resp_req_o), 128'(0));
    applyStimulus();
    applyStimulus();
    chk("d_err_sticky", 128'(err_o), 128'(1));

    // Traffic with the error still set, then async reset mid-cycle.
    randomTraffic(20);
    @(posedge clk);
    #1;
    req_req_i = 4'b1111;
    #1;
    rst_i = 1'b1;
    #1;
    chk("e_exu_req", 128'(exu_req_o), 128'(0));
    chk("e_req_ack", 128'(req_ack_o), 128'(0));
    chk("e_resp_req", 128'(resp_req_o), 128'(0));
    chk("e_err", 128'(err_o), 128'(0));
    doReset();

    // Long randomized run against the model.
    randomTraffic(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
